instr_queue: RTL and testbench
==============================

# instr_queue

Decoupling FIFO between instruction fetch and the decode/control stage of the out-of-order core. Fetch pushes one instruction word plus its PC per cycle. Decode pops one per cycle when it can accept it. The whole queue is discarded in one cycle on a branch redirect (taken branch, BR, or BL) so that no wrong-path instruction reaches the control decoder.

## Interface
Parameters:
- DEPTH, 8: number of entries; must be a power of two, ≥ 2.
- INSTR_W, 32: instruction word width. Decode consumes the low 18 bits as its `instr` input.
- PC_W, 64: program counter width.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- enq_valid, in, 1: fetch presents an instruction this cycle.
- enq_ready, out, 1: queue accepts; equals !full.
- enq_instr, in, INSTR_W: instruction word.
- enq_pc, in, PC_W: PC of enq_instr.
- deq_valid, out, 1: head entry is valid; equals !empty.
- deq_ready, in, 1: decode consumes the head this cycle.
- deq_instr, out, INSTR_W: head instruction word; don't-care when deq_valid=0.
- deq_pc, out, PC_W: head PC.
- flush, in, 1: redirect; discards all entries.
- count, out, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.

## Operation
- Storage is a circular buffer with a head pointer and a tail pointer. Each pointer is $clog2(DEPTH)+1 bits; the MSB is a wrap bit.
  - empty = (head == tail).
  - full = (index bits equal) && (wrap bits differ).
- Enqueue fires when enq_valid && enq_ready. It writes the entry at tail and increments tail.
- Dequeue fires when deq_valid && deq_ready. It increments head.
- Both may fire in the same cycle. count is then unchanged, and the pointers advance independently.
- Full: enq_ready=0 even if a dequeue fires that cycle; there is no full-bypass. A dequeue on a full queue frees a slot for the next cycle.
- Empty: deq_valid=0. An enqueue into an empty queue is not bypassed; it appears at the output the next cycle.
- flush has priority over enq and deq in the same cycle. Both pointers are set to 0, count to 0, and the incoming enq is dropped even though enq_ready may be 1. Fetch must not expect it to be stored.
- reset behaves like flush and also forces all outputs to their reset values. Reset mid-operation discards all contents.
- Pointer increment is modulo 2·DEPTH; the index wraps naturally at DEPTH.
- count = tail − head, modulo 2·DEPTH.
- Entry contents are never cleared; only the pointers define validity.

## Timing
- Reset values: enq_ready=1, deq_valid=0, count=0. deq_instr and deq_pc are don't-care (array not reset).
- Enqueue-to-dequeue latency is 1 cycle minimum: an entry written at edge N is visible on deq_* after edge N.
- deq_instr, deq_pc and deq_valid are driven combinationally from registered state (head pointer plus array read). They have no combinational path from enq_* or deq_ready.
- enq_ready depends only on registered state. It does not depend combinationally on deq_ready or flush.
- After flush at edge N: deq_valid=0 and count=0 after edge N. The next enqueue is accepted at edge N+1.
- Sustained throughput is 1 instruction/cycle when neither side stalls and the queue is non-empty and non-full.

## Structure
- Shared package `core_pkg`:
  - `instr_t` typedef, logic [INSTR_W-1:0].
  - `pc_t` typedef, logic [PC_W-1:0].
  - the INSTR_W and PC_W constants.
- Sub-module `instr_queue_mem`: DEPTH×(INSTR_W+PC_W) register array.
  - One synchronous write port (we, waddr, wdata).
  - One asynchronous read port (raddr, rdata).
  - No reset.
- Pointer, count and flag logic live in instr_queue.

## Test plan
- Reset then fill: assert reset 2 cycles, then enqueue 8 words 0x100..0x107 with PCs 0,4,..,28 while deq_ready=0.
  - After each accept, count reads 1..8.
  - After the 8th, enq_ready=0.
  - A 9th enq_valid is not stored.
- Drain in order: from full, deq_ready=1 for 8 cycles.
  - deq_instr reads 0x100..0x107 in order, with matching PCs.
  - deq_valid falls after the last, count=0, enq_ready=1 after the first pop.
- Simultaneous push/pop and wrap: with count=3, stream 20 enqueues at one per cycle with deq_ready=1.
  - count stays 3.
  - Output order is exactly the input order across multiple pointer wraps.
- Flush priority: with count=5, assert flush together with enq_valid=1 (instr 0xDEAD) and deq_ready=1.
  - Next cycle count=0 and deq_valid=0.
  - 0xDEAD never appears at deq_instr.
- Empty no-bypass: on an empty queue, enqueue 0xABC at edge N.
  - deq_valid=0 during cycle N.
  - deq_valid=1 with deq_instr=0xABC after edge N.
- Reset mid-stream: with count=4, assert reset for 1 cycle.
  - Outputs return to reset values.
  - The next enqueued word 0x55 is the first dequeued.

Source files
------------

// File: rtl/core_pkg.sv
// Types and width constants shared by the fetch, decode and queue blocks.
package core_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 64;

  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [PC_W-1:0]    pc_t;

endpackage : core_pkg

// File: rtl/instr_queue_mem.sv
// Storage array for the instruction queue: one synchronous write port and
// one asynchronous read port.
module instr_queue_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 96,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: the array is deliberately left without a reset; validity is defined
  // only by the queue pointers, so clearing entries would only cost flops.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule : instr_queue_mem

// File: rtl/instr_queue.sv
// Fetch-to-decode decoupling FIFO with a single-cycle discard on redirect.
// Head/tail pointers carry an extra wrap bit to separate full from empty.
module instr_queue #(
  parameter int DEPTH   = 8,
  parameter int INSTR_W = core_pkg::INSTR_W,
  parameter int PC_W    = core_pkg::PC_W,
  localparam int AW     = $clog2(DEPTH),
  localparam int PW     = AW + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_valid,
  output logic               enq_ready,
  input  logic [INSTR_W-1:0] enq_instr,
  input  logic [PC_W-1:0]    enq_pc,
  output logic               deq_valid,
  input  logic               deq_ready,
  output logic [INSTR_W-1:0] deq_instr,
  output logic [PC_W-1:0]    deq_pc,
  input  logic               flush,
  output logic [PW-1:0]      count
);

  localparam int EW = INSTR_W + PC_W;

  logic [PW-1:0] head, tail;
  logic          empty, full;
  logic          enq_fire, deq_fire, clear;
  logic [EW-1:0] rdata;

  assign empty = (head == tail);
  assign full  = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);

  assign enq_ready = !full;
  assign deq_valid = !empty;
  assign count     = tail - head;

  assign clear    = reset || flush;
  assign enq_fire = enq_valid && enq_ready && !clear;
  assign deq_fire = deq_valid && deq_ready;

  // NOTE: sequential state uses non-blocking assignments so every pointer
  // update sees the pre-edge values of both pointers.
  always_ff @(posedge clk) begin
    if (clear) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (enq_fire) tail <= tail + PW'(1);
      if (deq_fire) head <= head + PW'(1);
    end
  end

  instr_queue_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_mem (
    .clk   (clk),
    .we    (enq_fire),
    .waddr (tail[AW-1:0]),
    .wdata ({enq_instr, enq_pc}),
    .raddr (head[AW-1:0]),
    .rdata (rdata)
  );

  assign {deq_instr, deq_pc} = rdata;

endmodule : instr_queue

// File: tb/tb_instr_queue.sv
// Directed plus randomized bench for instr_queue against a queue-based model.
module tb_instr_queue;
  import core_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset, enq_valid, enq_ready, deq_valid, deq_ready, flush;
  instr_t     enq_instr, deq_instr;
  pc_t        enq_pc, deq_pc;
  logic [3:0] count;

  typedef struct packed {
    instr_t instr;
    pc_t    pc;
  } ent_t;

  ent_t q[$];
  int   tests = 0;
  int   fails = 0;

  instr_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_instr (enq_instr),
    .enq_pc    (enq_pc),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_instr (deq_instr),
    .deq_pc    (deq_pc),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every visible output against the model's view of the queue.
  task automatic check_all(input string tag);
    check({tag, ".count"}, 64'(count), 64'(q.size()));
    check({tag, ".deq_valid"}, 64'(deq_valid), 64'(q.size() != 0));
    check({tag, ".enq_ready"}, 64'(enq_ready), 64'(q.size() < DEPTH));
    if (q.size() != 0) begin
      check({tag, ".deq_instr"}, 64'(deq_instr), 64'(q[0].instr));
      check({tag, ".deq_pc"}, deq_pc, q[0].pc);
    end
  endtask

  // Drive one cycle, advance the model with the same rules, sample #1 after the edge.
  task automatic cycle(input logic ev, input instr_t ins, input pc_t pc,
                       input logic dr, input logic fl, input logic rst);
    bit acc, pop;
    enq_valid = ev; enq_instr = ins; enq_pc = pc;
    deq_ready = dr; flush = fl; reset = rst;
    acc = ev && (q.size() < DEPTH);
    pop = dr && (q.size() != 0);
    if (rst || fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{instr: ins, pc: pc});
    end
    @(posedge clk);
    #1;
    enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0; reset = 1'b0;
  endtask

  initial begin
    enq_valid = 1'b0; enq_instr = '0; enq_pc = '0;
    deq_ready = 1'b0; flush = 1'b0; reset = 1'b1;

    // Reset for two cycles.
    cycle(0, '0, '0, 0, 0, 1);
    cycle(0, '0, '0, 0, 0, 1);
    check_all("reset");
    check("reset.count0", 64'(count), 64'd0);
    check("reset.ready1", 64'(enq_ready), 64'd1);

    // Fill with 0x100.. and PCs 0,4,...
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, instr_t'(32'h100 + i), pc_t'(4 * i), 0, 0, 0);
      check("fill.count", 64'(count), 64'(i + 1));
    end
    check("fill.full_ready", 64'(enq_ready), 64'd0);
    cycle(1, 32'h1FF, 64'hFFFF, 0, 0, 0);
    check_all("fill.ninth");

    // Drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      check("drain.instr", 64'(deq_instr), 64'(32'h100 + i));
      check("drain.pc", deq_pc, 64'(4 * i));
      cycle(0, '0, '0, 1, 0, 0);
      if (i == 0) check("drain.ready_after_pop", 64'(enq_ready), 64'd1);
    end
    check("drain.valid0", 64'(deq_valid), 64'd0);
    check("drain.count0", 64'(count), 64'd0);

    // Simultaneous push/pop across several pointer wraps.
    for (int i = 0; i < 3; i++) cycle(1, instr_t'(32'h200 + i), pc_t'(i), 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(1, instr_t'(32'h300 + i), pc_t'(64'h1000 + i), 1, 0, 0);
      check("stream.count3", 64'(count), 64'd3);
      check_all("stream");
    end

    // Flush beats a concurrent enqueue and dequeue.
    for (int i = 0; i < 2; i++) cycle(1, instr_t'(32'h400 + i), pc_t'(i), 0, 0, 0);
    check("flush.pre_count5", 64'(count), 64'd5);
    cycle(1, 32'hDEAD, 64'h40, 1, 1, 0);
    check("flush.count0", 64'(count), 64'd0);
    check("flush.valid0", 64'(deq_valid), 64'd0);
    cycle(0, '0, '0, 1, 0, 0);
    check("flush.still_empty", 64'(deq_valid), 64'd0);

    // Empty queue: no bypass.
    enq_valid = 1'b1; enq_instr = 32'hABC; #1;
    check("nobypass.before", 64'(deq_valid), 64'd0);
    cycle(1, 32'hABC, 64'h80, 0, 0, 0);
    check("nobypass.after_valid", 64'(deq_valid), 64'd1);
    check("nobypass.after_instr", 64'(deq_instr), 64'hABC);

    // Reset mid-stream.
    for (int i = 0; i < 3; i++) cycle(1, instr_t'(32'h500 + i), pc_t'(i), 0, 0, 0);
    check("rstmid.pre_count4", 64'(count), 64'd4);
    cycle(1, 32'h600, '0, 1, 0, 1);
    check_all("rstmid");
    check("rstmid.valid0", 64'(deq_valid), 64'd0);
    cycle(1, 32'h55, 64'h5500, 0, 0, 0);
    check("rstmid.first", 64'(deq_instr), 64'h55);
    cycle(0, '0, '0, 1, 0, 0);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), instr_t'($urandom), {32'($urandom), 32'($urandom)},
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0), 1'b0);
      check_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_instr_queue
